// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing for the async-FIFO read-side drain logic.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } drain_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int BCNT_W    = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry valid/ready skid buffer: push at tail, pop at head, synchronous clear.
module fifo_skid_buf2
    import fifo_drain_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    input  logic              clear,
    output logic [DWIDTH-1:0] head,
    output logic [BCNT_W-1:0] count
);

    logic [DWIDTH-1:0] mem_reg [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [BCNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + BCNT_W'(push) - BCNT_W'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    mem_reg[gi] <= '0;
                else if (push && !clear && wr_ptr_reg == PTR_W'(gi))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fifo_read_drain.sv
// Read-side consumer of the async FIFO: pops into a 2-entry skid buffer feeding a valid/ready stream.
// Optional pop/drop statistics counters are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_read_drain
    import fifo_drain_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              RCLK,
    input  logic              RRST_n,
    input  logic              EN,
    input  logic              FLUSH,
    input  logic              REMPTY,
    input  logic [DWIDTH-1:0] RDATA,
    output logic              RINC,
    output logic              O_VALID,
    input  logic              O_READY,
    output logic [DWIDTH-1:0] O_DATA,
    output logic              FLUSH_DONE
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [CNT_W-1:0]  POP_CNT,
    output logic [CNT_W-1:0]  DROP_CNT
`endif
);

    drain_state_t      state_reg;
    drain_state_t      state_next;
    logic              rinc_comb;
    logic              in_flush;
    logic              flush_entry;
    logic              buf_push;
    logic              xfer;
    logic              flush_done_reg;
    logic [BCNT_W-1:0] buf_count;

    assign in_flush    = (state_reg == fifo_drain_pkg::FLUSH);
    // A flush request while already flushing is ignored, so it never re-clears or re-counts.
    assign flush_entry = FLUSH && !in_flush;

    always_ff @(posedge RCLK or negedge RRST_n) begin
        if (!RRST_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rinc_comb  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (EN) state_next = STREAM;
            end
            STREAM: begin
                rinc_comb = !REMPTY && (buf_count < BCNT_W'(BUF_DEPTH));
                if (!EN) state_next = IDLE;
            end
            fifo_drain_pkg::FLUSH: begin
                rinc_comb = !REMPTY;
                if (REMPTY) state_next = EN ? STREAM : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush_entry) state_next = fifo_drain_pkg::FLUSH;
    end

    assign RINC     = rinc_comb;
    assign buf_push = rinc_comb && !in_flush;
    assign O_VALID  = (buf_count != '0) && !in_flush;
    assign xfer     = O_VALID && O_READY;

    fifo_skid_buf2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk       (RCLK),
        .rst_n     (RRST_n),
        .push      (buf_push),
        .push_data (RDATA),
        .pop       (xfer),
        .clear     (flush_entry),
        .head      (O_DATA),
        .count     (buf_count)
    );

    // Registered so the pulse lands in the first cycle after FLUSH is left.
    always_ff @(posedge RCLK or negedge RRST_n) begin
        if (!RRST_n)
            flush_done_reg <= 1'b0;
        else
            flush_done_reg <= in_flush && REMPTY;
    end

    assign FLUSH_DONE = flush_done_reg;

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_W-1:0] pop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_inc;

    // On flush entry the discarded words are what the buffer would have held after this edge.
    always_comb begin
        drop_inc = '0;
        if (flush_entry)
            drop_inc = CNT_W'(buf_count) + CNT_W'(buf_push) - CNT_W'(xfer);
        else if (in_flush && rinc_comb)
            drop_inc = CNT_W'(1);
    end

    always_ff @(posedge RCLK or negedge RRST_n) begin
        if (!RRST_n) begin
            pop_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            pop_cnt_reg  <= pop_cnt_reg + CNT_W'(xfer);
            drop_cnt_reg <= drop_cnt_reg + drop_inc;
        end
    end

    assign POP_CNT  = pop_cnt_reg;
    assign DROP_CNT = drop_cnt_reg;
`endif

endmodule
